// File: rtl/qtcore_scan_pkg.sv
// Shared constants and state encoding for the qtcore scan-chain driver.
package qtcore_scan_pkg;

    localparam int CHAIN_LEN_DEFAULT = 168;
    localparam int BYTES             = CHAIN_LEN_DEFAULT / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        EMIT  = 2'd3
    } scan_state_e;

endpackage

// File: rtl/scan_byte_serdes.sv
// One byte of scan traffic: parallel-in/serial-out toward the chain head and
// serial-in/parallel-out from the chain tail, with a bit counter.
module scan_byte_serdes (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] load_data,
    input  logic       ser_in,
    output logic       ser_out,
    output logic [7:0] par_out,
    output logic       last_bit
);

    logic [7:0] tx_sr_r;
    logic [7:0] rx_sr_r;
    logic [2:0] bit_cnt_r;

    // Shift registers and bit counter; MSB leaves first, tail bit enters at LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr_r   <= 8'h00;
            rx_sr_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
        end else if (load) begin
            tx_sr_r   <= load_data;
            bit_cnt_r <= 3'd0;
        end else if (shift) begin
            tx_sr_r   <= {tx_sr_r[6:0], 1'b0};
            rx_sr_r   <= {rx_sr_r[6:0], ser_in};
            bit_cnt_r <= bit_cnt_r + 3'd1;
        end else begin
            tx_sr_r   <= tx_sr_r;
            rx_sr_r   <= rx_sr_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    assign ser_out  = tx_sr_r[7];
    assign par_out  = rx_sr_r;
    assign last_bit = (bit_cnt_r == 3'd7);

endmodule

// File: rtl/qtcore_scan_driver.sv
// Byte-stream initiator for the qtcore scan chain: loads a new chain image
// while unloading the previous one, one byte per LOAD/SHIFT/EMIT round.
module qtcore_scan_driver
    import qtcore_scan_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       scan_enable_n,
    output logic       scan_in,
    input  logic       scan_out
);

    localparam int               NUM_BYTES = CHAIN_LEN / 8;
    localparam int               CNT_W     = $clog2(NUM_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    scan_state_e      state_r;
    logic [CNT_W-1:0] byte_cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             out_valid_r;
    logic             scan_enable_n_r;

    logic             load_s;
    logic             shift_s;
    logic             last_bit_s;

    assign in_ready = (state_r == LOAD);
    assign load_s   = (state_r == LOAD) && in_valid;
    assign shift_s  = (state_r == SHIFT);

    scan_byte_serdes u_serdes (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .shift     (shift_s),
        .load_data (in_data),
        .ser_in    (scan_out),
        .ser_out   (scan_in),
        .par_out   (out_data),
        .last_bit  (last_bit_s)
    );

    // Pass sequencing; scan_enable_n is a flop so the chain sees a clean,
    // registered enable that drops exactly on the handshake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            byte_cnt_r      <= '0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            out_valid_r     <= 1'b0;
            scan_enable_n_r <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= LOAD;
                        busy_r     <= 1'b1;
                        byte_cnt_r <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        state_r         <= SHIFT;
                        scan_enable_n_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (last_bit_s) begin
                        state_r         <= EMIT;
                        scan_enable_n_r <= 1'b1;
                        out_valid_r     <= 1'b1;
                    end
                end
                EMIT: begin
                    // Next byte is only taken once this one has been consumed.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        byte_cnt_r  <= byte_cnt_r + CNT_W'(1);
                        if (byte_cnt_r == LAST_BYTE) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            state_r <= LOAD;
                        end
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    busy_r          <= 1'b0;
                    out_valid_r     <= 1'b0;
                    scan_enable_n_r <= 1'b1;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign out_valid     = out_valid_r;
    assign scan_enable_n = scan_enable_n_r;

endmodule

// File: doc/qtcore_scan_driver.md
# qtcore_scan_driver

On-chip initiator for the qtcore scan chain. It accepts a chain image as a stream of bytes and shifts each byte serially into the chain. At the same time it captures the bits the chain shifts out and returns them as a byte stream, so one pass both loads new contents and unloads the old ones. It sits between a byte-wide host link (e.g. an SPI slave or UART) and the core's scan_enable/scan_in/scan_out pins, replacing bench- or pin-driven bit-banging.

## Interface
- CHAIN_LEN, 168, scan chain length in bits (24 control bits + 18 × 8 memory bits); must be a multiple of 8
- clk  in  1  system clock; the same clock that shifts the chain
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that begins a pass; ignored while busy
- busy  out  1  high from the start acceptance edge until done
- done  out  1  one-cycle pulse after the last output byte is accepted
- in_data  in  8  next chain-image byte
- in_valid  in  1  in_data valid
- in_ready  out  1  driver will take in_data on this edge
- out_data  out  8  captured byte; held stable while out_valid && !out_ready
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- scan_enable_n  out  1  to chain; low = chain shifts on this clk edge
- scan_in  out  1  serial data to chain
- scan_out  in  1  serial data from chain tail

## Operation
- States: IDLE, LOAD, SHIFT, EMIT.
- IDLE: on start, go to LOAD, set busy, clear byte_cnt.
- LOAD: in_ready = 1. On in_valid && in_ready, latch in_data into tx_sr and go to SHIFT with bit_cnt = 0.
- SHIFT: scan_enable_n = 0 for exactly 8 cycles. scan_in = tx_sr[7], MSB first. On each edge:
  - tx_sr shifts left;
  - rx_sr = {rx_sr[6:0], scan_out}.
  - After the 8th edge, go to EMIT.
- EMIT: out_data = rx_sr, out_valid = 1. On out_ready:
  - byte_cnt++;
  - if byte_cnt == CHAIN_LEN/8 − 1, pulse done, clear busy, go to IDLE;
  - otherwise go to LOAD.
- Ordering:
  - The first input byte lands in chain bits [CHAIN_LEN-1 -: 8].
  - The last input byte lands in [7:0] (state[2:0], PC[7:3]).
  - Output bytes follow the same ordering: the first byte returned is the old chain[CHAIN_LEN-1 -: 8].
- Stalls: in any state other than SHIFT, scan_enable_n = 1 and the chain holds its contents. Gaps on in_valid and back-pressure on out_ready therefore never corrupt the chain.
- No overlap: the next input byte is not accepted until the previous output byte has been consumed.
- start during busy: ignored, no effect.
- Reset mid-pass: scan_enable_n goes to 1 immediately (asynchronous) and the FSM returns to IDLE. The chain is left partially shifted; the host must rerun a full pass.

## Timing
- Reset values: busy 0, done 0, in_ready 0, out_valid 0, out_data 0x00, scan_enable_n 1, scan_in 0.
- All outputs are registered except in_ready, which is decoded from state.
- Edge numbering: the in_data handshake happens at edge t. scan_enable_n is low for the cycles ending at edges t+1 … t+8. out_valid rises after edge t+8.
- Minimum per byte is 10 cycles (1 LOAD + 8 SHIFT + 1 EMIT). A full 21-byte pass takes ≥ 210 cycles after start.
- scan_out is sampled on the same edge that shifts the chain, i.e. before the chain's new value appears.
- done is asserted in the cycle after the final out_valid && out_ready.

## Structure
- Package qtcore_scan_pkg holds:
  - the CHAIN_LEN default, 168;
  - localparam BYTES = CHAIN_LEN/8;
  - the state enum {IDLE, LOAD, SHIFT, EMIT}.
- One sub-module, scan_byte_serdes: an 8-bit PISO/SIPO pair with a 3-bit bit counter and a last-bit flag. The FSM and byte counter stay in the top.

## Test plan
- Full load into qtcore with the chain image state=001, PC=1, IR=E0, ACC=01, MEM[0..4]=E0..E4, top byte F0 -> after done, core holds exactly those values and LED output = 1111000.
- Run 8 processor cycles, then a second pass with an all-zero image -> returned bytes decode to state 001, PC 5, IR E4, ACC 0B, MEM[0..4] E0..E4.
- Back-pressure: hold out_ready low for 5 cycles in EMIT -> scan_enable_n stays 1, chain unchanged, out_data stable; the pass completes correctly afterwards.
- in_valid gaps of 0–7 random cycles, checked against a 168-bit loopback model -> second-pass output equals first-pass input.
- start pulsed while busy -> ignored; byte count and done timing unchanged (done once, after byte 21).
- rst_n low during SHIFT (bit 4 of byte 3) -> all outputs go to reset values immediately; a subsequent full pass loads correctly.
